clock_set_ctrl: RTL and testbench

//  Sequencing controller for the 24h HH:MM:SS timekeeper.
//  - Derives a 1 Hz seconds tick from the system clock.
//  - Debounces two user buttons.
//  - Runs a RUN / SET_HR / SET_MIN mode FSM that pauses timekeeping and issues

---
 rtl/clock_set_ctrl_if.sv | 23 ++
 rtl/clock_set_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_set_ctrl_if.sv
// Button inputs and timekeeper command outputs of the clock set controller.
// master: the side that drives the buttons and consumes the commands.
// slave:  the controller itself.
interface clock_set_ctrl_if;
  logic       btn_mode;
  logic       btn_inc;
  logic       sec_tick;
  logic       min_inc;
  logic       hour_inc;
  logic       sec_clr;
  logic [1:0] mode;
  logic       blink;

  modport master (
    output btn_mode, btn_inc,
    input  sec_tick, min_inc, hour_inc, sec_clr, mode, blink
  );

  modport slave (
    input  btn_mode, btn_inc,
    output sec_tick, min_inc, hour_inc, sec_clr, mode, blink
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Sequencing controller for a 24h HH:MM:SS timekeeper: 1 Hz tick prescaler,
// two debounced buttons, RUN / SET_HR / SET_MIN mode FSM issuing single-step
// edit commands, and a blink enable for the field being edited.
// Optional feature: define AUTOREPEAT_EN to add inc auto-repeat while held in
// a SET state (REPEAT_DELAY before the first repeat, then every REPEAT_RATE).
module clock_set_ctrl #(
  parameter int TICK_DIV     = 50_000_000,
  parameter int DEB_CYCLES   = 1_000_000,
  parameter int BLINK_DIV    = 12_500_000,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000
) (
  input  logic                   clk,
  input  logic                   clr,
  clock_set_ctrl_if.slave        ctl
);

  localparam int TICK_W  = $clog2(TICK_DIV);
  localparam int DEB_W   = $clog2(DEB_CYCLES);
  localparam int BLINK_W = $clog2(BLINK_DIV);

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10,
    BAD     = 2'b11
  } mode_e;

  // Index 0 = mode button, index 1 = inc button
  logic [1:0]       sync1, sync2, deb, deb_d;
  logic [DEB_W-1:0] deb_cnt [2];

  mode_e state, state_nxt;

  logic [TICK_W-1:0]  presc;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_q;

  logic mode_press, inc_press, in_set, rep_due, inc_fire;
  logic tick_nxt, hour_nxt, min_nxt, clr_nxt;
  logic sec_tick_q, hour_inc_q, min_inc_q, sec_clr_q;

  assign mode_press = deb[0] & ~deb_d[0];
  assign inc_press  = deb[1] & ~deb_d[1];
  assign in_set     = (state == SET_HR) || (state == SET_MIN);

  // Two-flop synchronizers for the asynchronous raw buttons
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {ctl.btn_inc, ctl.btn_mode};
      sync2 <= sync1;
    end
  end

  // Debounce: accept a new level only after it has held for DEB_CYCLES cycles
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      deb     <= '0;
      deb_d   <= '0;
      deb_cnt <= '{default: '0};
    end else begin
      deb_d <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX);
  localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_act, rep_first, rep_hold;

  // Repeat keeps running only while inc stays held in the same SET state
  assign rep_hold = rep_act && deb[1] && in_set && !mode_press;
  assign rep_due  = rep_hold && (rep_first ? (rep_cnt == DELAY_LAST) : (rep_cnt == RATE_LAST));

  // Auto-repeat timer: armed by an accepted inc press, long first interval
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rep_act   <= 1'b0;
      rep_first <= 1'b0;
      rep_cnt   <= '0;
    end else if (in_set && !mode_press && inc_press) begin
      rep_act   <= 1'b1;
      rep_first <= 1'b1;
      rep_cnt   <= '0;
    end else if (rep_hold) begin
      if (rep_due) begin
        rep_first <= 1'b0;
        rep_cnt   <= '0;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end else begin
      rep_act   <= 1'b0;
      rep_first <= 1'b0;
      rep_cnt   <= '0;
    end
  end
`else
  assign rep_due = 1'b0;
`endif

  // Mode state register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= RUN;
    else      state <= state_nxt;
  end

  // Mode sequencing; the unused encoding falls back to RUN
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (mode_press) state_nxt = SET_HR;
      SET_HR:  if (mode_press) state_nxt = SET_MIN;
      SET_MIN: if (mode_press) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Command decode; a mode press in the same cycle swallows any inc request
  always_comb begin
    inc_fire = in_set && !mode_press && (inc_press || rep_due);
    hour_nxt = inc_fire && (state == SET_HR);
    min_nxt  = inc_fire && (state == SET_MIN);
    clr_nxt  = (state == SET_MIN) && (state_nxt == RUN);
    tick_nxt = (state == RUN) && !mode_press && (presc == TICK_LAST);
  end

  // Seconds prescaler: free-runs in RUN, parked at 0 while editing
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)                    presc <= '0;
    else if (state != RUN)       presc <= '0;
    else if (presc == TICK_LAST) presc <= '0;
    else                         presc <= presc + 1'b1;
  end

  // Blink phase: restarted on SET entry and on every edit so the new digit shows
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      blink_cnt <= '0;
      blink_q   <= 1'b0;
    end else if (state_nxt == RUN || state_nxt != state || inc_fire) begin
      blink_cnt <= '0;
      blink_q   <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_q   <= ~blink_q;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Registered command pulses
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sec_tick_q <= 1'b0;
      hour_inc_q <= 1'b0;
      min_inc_q  <= 1'b0;
      sec_clr_q  <= 1'b0;
    end else begin
      sec_tick_q <= tick_nxt;
      hour_inc_q <= hour_nxt;
      min_inc_q  <= min_nxt;
      sec_clr_q  <= clr_nxt;
    end
  end

  assign ctl.sec_tick = sec_tick_q;
  assign ctl.hour_inc = hour_inc_q;
  assign ctl.min_inc  = min_inc_q;
  assign ctl.sec_clr  = sec_clr_q;
  assign ctl.mode     = state;
  assign ctl.blink    = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl with small divider values; a cycle-level reference
// model derived from the behavioural rules runs alongside and every output is
// compared each cycle, plus scenario-level pulse counts and latencies.
module tb_clock_set_ctrl;
  localparam int TD = 10;
  localparam int DB = 4;
  localparam int BD = 3;
  localparam int RD = 8;
  localparam int RR = 4;

  logic clk;
  logic clr;
  clock_set_ctrl_if ctl_if ();

  clock_set_ctrl #(
    .TICK_DIV(TD), .DEB_CYCLES(DB), .BLINK_DIV(BD),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk),
    .clr(clr),
    .ctl(ctl_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_d1[2], m_d2[2], m_lvl[2], m_run[2], m_rose[2];
  int m_mode, m_runcnt, m_age, m_repon, m_repage;
  bit e_tick, e_min, e_hour, e_clr, e_blink;
  int raw_v[2], syn_v[2], lvl_old[2];
  bit mp, ip, due, fire;
  int nm;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int b = 0; b < 2; b++) begin
        m_d1[b] = 0; m_d2[b] = 0; m_lvl[b] = 0; m_run[b] = 0; m_rose[b] = 0;
      end
      m_mode = 0; m_runcnt = 0; m_age = 0; m_repon = 0; m_repage = 0;
      e_tick = 0; e_min = 0; e_hour = 0; e_clr = 0; e_blink = 0;
    end else begin
      raw_v[0] = int'(ctl_if.btn_mode);
      raw_v[1] = int'(ctl_if.btn_inc);
      mp = (m_rose[0] != 0);
      ip = (m_rose[1] != 0);
      for (int b = 0; b < 2; b++) begin
        syn_v[b]   = m_d2[b];
        m_d2[b]    = m_d1[b];
        m_d1[b]    = raw_v[b];
        lvl_old[b] = m_lvl[b];
        m_rose[b]  = 0;
        if (syn_v[b] != m_lvl[b]) begin
          m_run[b]++;
          if (m_run[b] == DB) begin
            m_lvl[b]  = syn_v[b];
            m_run[b]  = 0;
            m_rose[b] = syn_v[b];
          end
        end else begin
          m_run[b] = 0;
        end
      end
      nm  = mp ? (m_mode + 1) % 3 : m_mode;
      due = 0;
      if (m_mode != 0 && !mp && ip) begin
        m_repon = 1; m_repage = 0;
      end else if (m_repon != 0 && lvl_old[1] == 1 && m_mode != 0 && !mp) begin
        m_repage++;
        due = (m_repage == RD) || (m_repage > RD && ((m_repage - RD) % RR) == 0);
      end else begin
        m_repon = 0;
      end
`ifndef AUTOREPEAT_EN
      due = 0;
`endif
      fire   = (m_mode != 0) && !mp && (ip || due);
      e_clr  = (m_mode == 2) && mp;
      e_hour = fire && (m_mode == 1);
      e_min  = fire && (m_mode == 2);
      if (m_mode == 0 && !mp) begin
        m_runcnt++;
        e_tick = (m_runcnt % TD) == 0;
      end else begin
        m_runcnt = 0;
        e_tick   = 0;
      end
      if (nm == 0 || nm != m_mode || fire) begin
        m_age = 0; e_blink = 0;
      end else begin
        m_age++;
        e_blink = ((m_age / BD) % 2) == 1;
      end
      m_mode = nm;
    end
  end

  // ---------------- per-cycle checker ----------------
  int cyc = 0;
  int n_tick = 0, n_hour = 0, n_min = 0, n_sclr = 0, n_mchg = 0;
  int mode_chg_cyc = 0, clr_cyc = 0, tick_gap = -1;
  bit gap_armed = 0;
  logic [1:0] prev_mode = 2'b00;

  always @(negedge clk) begin
    cyc++;
    chk("sec_tick", 32'(ctl_if.sec_tick), 32'(e_tick));
    chk("hour_inc", 32'(ctl_if.hour_inc), 32'(e_hour));
    chk("min_inc",  32'(ctl_if.min_inc),  32'(e_min));
    chk("sec_clr",  32'(ctl_if.sec_clr),  32'(e_clr));
    chk("mode",     32'(ctl_if.mode),     32'(m_mode));
    chk("blink",    32'(ctl_if.blink),    32'(e_blink));
    chk("excl", 32'($countones({ctl_if.sec_tick, ctl_if.hour_inc, ctl_if.min_inc, ctl_if.sec_clr}) <= 1), 32'd1);
    if (ctl_if.sec_tick) begin
      n_tick++;
      if (gap_armed) begin
        tick_gap  = cyc - clr_cyc;
        gap_armed = 0;
      end
    end
    if (ctl_if.hour_inc) n_hour++;
    if (ctl_if.min_inc)  n_min++;
    if (ctl_if.sec_clr) begin
      n_sclr++;
      clr_cyc   = cyc;
      gap_armed = 1;
    end
    if (ctl_if.mode !== prev_mode) begin
      n_mchg++;
      mode_chg_cyc = cyc;
    end
    prev_mode = ctl_if.mode;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic set_btn(input int b, input logic v);
    if (b == 0) ctl_if.btn_mode = v;
    else        ctl_if.btn_inc  = v;
  endtask

  // Press with 0..2 short glitches first, then a clean hold and release gap
  task automatic press(input int b, input int hold, input int gap);
    int nb;
    nb = $urandom_range(0, 2);
    for (int k = 0; k < nb; k++) begin
      set_btn(b, 1'b1); idle($urandom_range(1, 2));
      set_btn(b, 1'b0); idle($urandom_range(1, 2));
    end
    set_btn(b, 1'b1); idle(hold);
    set_btn(b, 1'b0); idle(gap);
  endtask

  int s_tick, s_hour, s_min, s_sclr, s_mchg, c0, exp_rep;

  initial begin
    ctl_if.btn_mode = 1'b0;
    ctl_if.btn_inc  = 1'b0;
    clr = 1'b0;

    // reset state
    idle(3);
    chk("rst_mode", 32'(ctl_if.mode), 32'd0);
    chk("rst_pulses", 32'({ctl_if.sec_tick, ctl_if.hour_inc, ctl_if.min_inc, ctl_if.sec_clr}), 32'd0);
    chk("rst_blink", 32'(ctl_if.blink), 32'd0);
    clr = 1'b1;

    // idle run: ticks at 10, 20, 30
    s_tick = n_tick; s_mchg = n_mchg;
    idle(35);
    chk("idle_ticks", 32'(n_tick - s_tick), 32'd3);
    chk("idle_modechg", 32'(n_mchg - s_mchg), 32'd0);

    // bouncing mode button, single change 7 cycles after the final rise
    s_mchg = n_mchg;
    set_btn(0, 1'b1); idle(2);
    set_btn(0, 1'b0); idle(2);
    set_btn(0, 1'b1); c0 = cyc;
    idle(12);
    set_btn(0, 1'b0); idle(10);
    chk("bounce_modechg", 32'(n_mchg - s_mchg), 32'd1);
    chk("bounce_latency", 32'(mode_chg_cyc - c0), 32'd7);
    chk("set_hr_mode", 32'(ctl_if.mode), 32'd1);

    // edits: 3 x hour, mode, 2 x minute
    s_hour = n_hour; s_min = n_min; s_tick = n_tick;
    for (int i = 0; i < 3; i++) press(1, $urandom_range(5, 8), $urandom_range(8, 12));
    press(0, $urandom_range(6, 12), 10);
    for (int i = 0; i < 2; i++) press(1, $urandom_range(5, 8), $urandom_range(8, 12));
    chk("edit_hour", 32'(n_hour - s_hour), 32'd3);
    chk("edit_min", 32'(n_min - s_min), 32'd2);
    chk("edit_mode", 32'(ctl_if.mode), 32'd2);
    chk("edit_ticks", 32'(n_tick - s_tick), 32'd0);

    // leave SET_MIN: sec_clr then first tick exactly TICK_DIV later
    s_sclr = n_sclr;
    tick_gap = -1;
    press(0, $urandom_range(6, 12), 10);
    idle(15);
    chk("exit_sclr", 32'(n_sclr - s_sclr), 32'd1);
    chk("exit_gap", 32'(tick_gap), 32'(TD));
    chk("exit_mode", 32'(ctl_if.mode), 32'd0);

    // simultaneous debounced edges in SET_HR: mode wins
    press(0, 8, 10);
    chk("simul_pre_mode", 32'(ctl_if.mode), 32'd1);
    s_hour = n_hour; s_min = n_min;
    ctl_if.btn_mode = 1'b1; ctl_if.btn_inc = 1'b1;
    idle(8);
    ctl_if.btn_mode = 1'b0; ctl_if.btn_inc = 1'b0;
    idle(10);
    chk("simul_mode", 32'(ctl_if.mode), 32'd2);
    chk("simul_incs", 32'((n_hour - s_hour) + (n_min - s_min)), 32'd0);

    // long hold in SET_MIN
`ifdef AUTOREPEAT_EN
    exp_rep = 7;
`else
    exp_rep = 1;
`endif
    s_min = n_min;
    set_btn(1, 1'b1); idle(30);
    set_btn(1, 1'b0); idle(10);
    chk("hold_min", 32'(n_min - s_min), 32'(exp_rep));

    // asynchronous reset mid-SET_MIN with inc held
    set_btn(1, 1'b1); idle(10);
    clr = 1'b0;
    #1;
    chk("async_mode", 32'(ctl_if.mode), 32'd0);
    chk("async_pulses", 32'({ctl_if.sec_tick, ctl_if.hour_inc, ctl_if.min_inc, ctl_if.sec_clr}), 32'd0);
    idle(3);
    clr = 1'b1;
    idle(15);
    set_btn(1, 1'b0); idle(10);
    s_hour = n_hour;
    press(0, 8, 10);
    chk("post_rst_mode", 32'(ctl_if.mode), 32'd1);
    chk("post_rst_noinc", 32'(n_hour - s_hour), 32'd0);
    press(1, 6, 10);
    chk("post_rst_inc", 32'(n_hour - s_hour), 32'd1);

    // random button activity against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) ctl_if.btn_mode = ~ctl_if.btn_mode;
      if ($urandom_range(0, 5) == 0) ctl_if.btn_inc  = ~ctl_if.btn_inc;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
